// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control FSM for DataPath.
// In: clock, clear(async low), run, mem_ready, IR. Out: registered strobes, Rin/Rout, opcode, status.
module control_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int IR_W     = 32,
  parameter int OPCODE_W = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [IR_W-1:0]     IR,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OPCODE_W-1:0] opcode,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic                halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_DEC,
    S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef struct packed {
    logic pcout, marin, incpc, pcin;
    logic read, mdrin, mdrout, irin;
    logic yin, zin, zlowout, zhighout;
    logic hiin, loin;
  } strb_t;

  localparam int RA_HI = IR_W - OPCODE_W - 1;
  localparam int RB_HI = RA_HI - REG_W;
  localparam int RC_HI = RB_HI - REG_W;

  state_t                r_state, w_next;
  strb_t                 r_s, w_s;
  logic [NUM_REGS-1:0]   r_rin, r_rout, w_rin, w_rout;
  logic [OPCODE_W-1:0]   r_opc, w_opc;
  logic                  r_busy, r_done, r_fault, r_halt;
  logic                  w_busy, w_done, w_fault, w_halt;

  logic [OPCODE_W-1:0]   w_op;
  logic [REG_W-1:0]      w_ra, w_rb, w_rc;
  logic [NUM_REGS-1:0]   w_oh_ra, w_oh_rb, w_oh_rc;
  logic                  w_bin, w_md, w_un, w_hlt, w_ill;
  logic                  w_unused;

  assign w_op = IR[IR_W-1 -: OPCODE_W];
  assign w_ra = IR[RA_HI -: REG_W];
  assign w_rb = IR[RB_HI -: REG_W];
  assign w_rc = IR[RC_HI -: REG_W];
  assign w_unused = ^IR;

  assign w_bin = (w_op >= OPCODE_W'(3)) && (w_op <= OPCODE_W'(14));
  assign w_md  = (w_op == OPCODE_W'(15)) || (w_op == OPCODE_W'(16));
  assign w_un  = (w_op == OPCODE_W'(18)) || (w_op == OPCODE_W'(19));
  assign w_hlt = (w_op == OPCODE_W'(27));
  assign w_ill = !(w_bin || w_md || w_un || w_hlt);

  // Field values >= NUM_REGS match no bit, giving an all-zero enable.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_oh_ra[i] = (w_ra == REG_W'(i));
      w_oh_rb[i] = (w_rb == REG_W'(i));
      w_oh_rc[i] = (w_rc == REG_W'(i));
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (run) w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1,
      S_T1W:  w_next = mem_ready ? S_T2 : S_T1W;
      S_T2:   w_next = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          w_bin, w_md, w_un: w_next = S_T3;
          w_hlt:             w_next = S_HALT;
          default:           w_next = S_IDLE;
        endcase
      end
      S_T3:   w_next = S_T4;
      S_T4:   w_next = S_T5;
      S_T5: begin
        if (w_md) w_next = S_T6;
        else      w_next = run ? S_T0 : S_IDLE;
      end
      S_T6:   w_next = run ? S_T0 : S_IDLE;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered,
  // so each strobe covers exactly the cycle spent in its state.
  always_comb begin
    w_s    = '0;
    w_rin  = '0;
    w_rout = '0;
    w_opc  = '0;
    w_busy = 1'b1;
    w_done = 1'b0;
    w_halt = 1'b0;
    w_fault = (r_state == S_DEC) && w_ill;
    unique case (w_next)
      S_IDLE: w_busy = 1'b0;
      S_T0: begin
        w_s.pcout = 1'b1;
        w_s.marin = 1'b1;
        w_s.incpc = 1'b1;
        w_s.zin   = 1'b1;
      end
      S_T1: begin
        w_s.zlowout = 1'b1;
        w_s.pcin    = 1'b1;
        w_s.read    = 1'b1;
        w_s.mdrin   = 1'b1;
      end
      S_T1W: begin
        w_s.read  = 1'b1;
        w_s.mdrin = 1'b1;
      end
      S_T2: begin
        w_s.mdrout = 1'b1;
        w_s.irin   = 1'b1;
      end
      S_DEC: ;
      S_T3: begin
        w_rout    = w_oh_rb;
        w_s.yin   = 1'b1;
      end
      S_T4: begin
        w_opc     = w_op;
        w_s.zin   = 1'b1;
        if (!w_un) w_rout = w_oh_rc;
      end
      S_T5: begin
        w_s.zlowout = 1'b1;
        if (w_md) begin
          w_s.loin = 1'b1;
        end else begin
          w_rin  = w_oh_ra;
          w_done = 1'b1;
        end
      end
      S_T6: begin
        w_s.zhighout = 1'b1;
        w_s.hiin     = 1'b1;
        w_done       = 1'b1;
      end
      S_HALT: begin
        w_busy = 1'b0;
        w_halt = 1'b1;
      end
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_rin   <= '0;
      r_rout  <= '0;
      r_opc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_s     <= w_s;
      r_rin   <= w_rin;
      r_rout  <= w_rout;
      r_opc   <= w_opc;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_fault <= w_fault;
      r_halt  <= w_halt;
    end
  end

  assign PCout    = r_s.pcout;
  assign MARin    = r_s.marin;
  assign IncPC    = r_s.incpc;
  assign PCin     = r_s.pcin;
  assign Read     = r_s.read;
  assign MDRin    = r_s.mdrin;
  assign MDRout   = r_s.mdrout;
  assign IRin     = r_s.irin;
  assign Yin      = r_s.yin;
  assign Zin      = r_s.zin;
  assign Zlowout  = r_s.zlowout;
  assign Zhighout = r_s.zhighout;
  assign HIin     = r_s.hiin;
  assign LOin     = r_s.loin;
  assign Rin      = r_rin;
  assign Rout     = r_rout;
  assign opcode   = r_opc;
  assign busy     = r_busy;
  assign done     = r_done;
  assign fault    = r_fault;
  assign halted   = r_halt;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised hardwired control unit that drives the DataPath control strobes through fetch (T0–T2) and execute (T3–T6) steps. It replaces hand-sequenced control with a state machine that decodes IR, supports binary, unary and HI/LO-writing (mul/div) instruction classes, stalls on memory, and can run instructions back-to-back. It sits beside DataPath: its outputs feed DataPath control inputs, and it reads IR back from DataPath.

## Interface
- NUM_REGS, 16, number of general registers; width of one-hot Rin/Rout
- REG_W, $clog2(NUM_REGS), width of each register field in IR
- IR_W, 32, instruction width
- OPCODE_W, 5, opcode field width; opcode = IR[IR_W-1 -: OPCODE_W]

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  reset; one clock, asynchronous, active-low
- run  in  1  level; start or continue execution
- mem_ready  in  1  memory read data valid; tie high for zero-wait memory
- IR  in  IR_W  current instruction register contents from DataPath
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  DataPath strobes
- Rin, Rout  out  NUM_REGS  one-hot register write/drive enables
- opcode  out  OPCODE_W  ALU operation; 0 when no ALU op is selected
- busy  out  1  high in every state except IDLE and HALT
- done  out  1  one-cycle pulse at end of each instruction
- fault  out  1  one-cycle pulse on illegal opcode
- halted  out  1  high in HALT

## Operation
- IR fields: Ra = IR[IR_W-OPCODE_W-1 -: REG_W]; Rb = next REG_W bits; Rc = next REG_W bits.
- Opcode classes:
  - BIN: 00011–01110.
  - MULDIV: 01111, 10000.
  - UNARY: 10010 (neg), 10011 (not).
  - HALT: 11011.
  - Every other opcode is illegal.
- States and asserted strobes (all other strobes 0):
  - IDLE: none. Goes to T0 when run = 1.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Goes to T2 if mem_ready = 1, else T1W.
  - T1W: Read, MDRin only. PCin is not re-asserted. Holds until mem_ready = 1, then goes to T2.
  - T2: MDRout, IRin.
  - DEC: no strobes; decodes IR.
    - BIN, UNARY, MULDIV: go to T3.
    - HALT: go to HALT.
    - Illegal: fault pulse, then IDLE.
  - T3: Rout[Rb], Yin.
  - T4: opcode = IR opcode, Zin. Rout[Rc] also asserted for BIN and MULDIV only; UNARY drives no register.
  - T5:
    - BIN/UNARY: Zlowout, Rin[Ra]; instruction completes.
    - MULDIV: Zlowout, LOin.
  - T6 (MULDIV only): Zhighout, HIin; instruction completes.
  - HALT: halted = 1. Exits only on clear.
- Completion: done pulses in the completing cycle. Next state is T0 if run = 1, else IDLE.
- Out-of-range register fields (value ≥ NUM_REGS) drive all-zero Rin/Rout. fault is not raised for this case.

## Timing
- All outputs are registered: each strobe is high for exactly the full clock cycle of its state.
- Reset values while clear = 0: every output 0 (opcode = 0, Rin/Rout = 0, done/fault/halted = 0); state = IDLE. Takes effect immediately, including mid-instruction.
- Start latency: run sampled high in IDLE gives T0 strobes in the next cycle.
- Instruction length with mem_ready tied high: 7 cycles (T0–T5) for BIN/UNARY, 8 for MULDIV. Each cycle mem_ready is low in T1/T1W adds one cycle.
- Back-to-back: T0 of the next instruction directly follows T5/T6, with no IDLE gap.
- run is only sampled in IDLE and at completion. Dropping run mid-instruction does not abort the instruction.
- mem_ready is ignored outside T1/T1W.
- IR is sampled in DEC through T6. IR must be stable from the end of T2 to instruction completion.

## Test plan
- Reset: clear low mid-T4 → all outputs 0 in the same cycle; after release with run = 0, module stays in IDLE with busy = 0.
- add R3,R1,R2 (IR = 0x19890000), mem_ready = 1, run pulsed:
  - T3: Rout = 0x0002, Yin = 1.
  - T4: Rout = 0x0004, opcode = 00011, Zin = 1.
  - T5: Rin = 0x0008, Zlowout = 1.
  - done pulses 7 cycles after T0 start.
- neg R5,R0 (IR = 0x92800000):
  - T3: Rout = 0x0001.
  - T4: Rout = 0, opcode = 10010.
  - T5: Rin = 0x0020.
- mul R6,R7 (IR = 0x78338000):
  - T3: Rout = 0x0040.
  - T4: Rout = 0x0080, opcode = 01111.
  - T5: LOin = 1.
  - T6: HIin = 1, Zhighout = 1.
  - done at T6.
- Memory stall: mem_ready low for 3 cycles after T1 entry →
  - T1W lasts 3 cycles with Read = MDRin = 1 and PCin = 0.
  - PCin high only in the single T1 cycle.
  - Instruction takes 10 cycles.
- Control opcodes:
  - IR = 0xF8000000 → fault pulse after T2, return to IDLE, Rin never asserted.
  - IR = 0xD8000000 → halted = 1, busy = 0, remains there with run = 1 until clear.
